request_unit_q: RTL
===================

// Module: request_unit_q
// PURPOSE
// Parametrised successor of the single-entry data request unit. Sits between the
// datapath and the memory control interface. Captures dmem read/write requests
// (address + store data) into a DEPTH-entry in-order queue on ihit, presents the
// head to memory, and retires the head on dhit. Adds halt draining (RUN/DRAIN/HALTED),
// flush of not-yet-issued entries, and a wait-cycle counter.
// PARAMETERS
// ADDR_W   32  address width
// DATA_W   32  store data width
// DEPTH    2   queue entries; power of 2, >=2
// CNT_W    16  width of wait_cnt, saturating
// PORTS
// CLK        in   1       clock, rising edge
// nRST       in   1       async active-low reset
// ihit       in   1       instruction fetch completes; enqueue strobe
// dhit       in   1       memory completed head request
// dREN       in   1       datapath requests load this instruction
// dWEN       in   1       datapath requests store this instruction
// daddr      in   ADDR_W  request address
// dstore     in   DATA_W  store data
// halt       in   1       datapath decoded halt
// flush      in   1       discard queued entries behind head
// imemren    out  1       instruction read enable
// dmemren    out  1       head is a load
// dmemwen    out  1       head is a store
// dmemaddr   out  ADDR_W  head address
// dmemstore  out  DATA_W  head store data
// full       out  1       count==DEPTH
// busy       out  1       count!=0
// halted     out  1       state==HALTED
// wait_cnt   out  CNT_W   cycles the current head has waited for dhit
// BEHAVIOUR
// - Reset (async, nRST=0): queue empty, ptrs/count 0, state RUN, wait_cnt 0;
//   outputs dmemren=dmemwen=0, dmemaddr=dmemstore=0, full=0, busy=0, halted=0, imemren=1.
// - Enqueue: when ihit & (dREN|dWEN) & state!=HALTED & (!full | dhit). The entry
//   is {ren=dREN&~dWEN, wen=dWEN, daddr, dstore}. dREN&dWEN together = store.
//   Enqueue while full without dhit is dropped. The datapath must stall on full.
// - Head outputs are registered queue contents: an entry enqueued at edge N
//   drives dmemren/dmemwen at cycle N+1 if the queue was empty. Latency is 1 cycle.
//   dmemren/dmemwen are 0 whenever the queue is empty. Address/data then hold their last value.
// - Dequeue: dhit & busy pops the head at the edge. dhit with the queue empty is ignored.
//   Simultaneous enqueue+dequeue leaves count unchanged. Pointers wrap mod DEPTH.
// - Flush: at the edge, count := busy ? 1 : 0. This keeps the in-flight head, because the
//   memory handshake cannot be cancelled. With dhit in the same cycle the queue
//   becomes empty. Flush takes priority over a same-cycle enqueue, which is dropped.
// - wait_cnt: 0 when empty or on a pop. Otherwise +1 per cycle, saturating at 2^CNT_W-1.
// - FSM:
//   RUN    -> DRAIN on halt. The halt cycle's own request is still enqueued.
//   DRAIN  -> HALTED when count==0, including the edge where the last dhit pops.
//   HALTED -> stays until reset. Flush and halt are ignored here.
//   imemren=1 in RUN, 0 in DRAIN/HALTED. halted=1 only in HALTED.
// - Reset mid-transaction discards all entries. The memory side must tolerate
//   dmemren/dmemwen dropping asynchronously.
// TESTING
// 1 Reset: nRST=0 with a full queue -> all outputs at their reset values
//   immediately; imemren=1, busy=0.
// 2 Single load: ihit,dREN,daddr=0x40 at edge 0 -> dmemren=1, addr=0x40 from
//   cycle 1; dhit at cycle 3 -> busy=0, wait_cnt shows 2 before the pop.
// 3 Fill/wrap (DEPTH=2): 2 stores enqueued -> full=1. A 3rd with no dhit is dropped.
//   A 3rd with dhit is accepted and count stays 2. Repeat 5x -> FIFO order of addresses kept.
// 4 Flush: 2 entries queued, flush -> count=1, head addr unchanged. Flush+dhit -> busy=0.
// 5 Halt drain: halt with 1 pending load -> imemren=0, halted=0 until dhit.
//   The edge after dhit -> halted=1, and a later ihit+dREN is not enqueued.
// 6 dREN&dWEN=1 -> dmemwen=1, dmemren=0. wait_cnt saturates at 0xFFFF under a long stall.

Source files
------------

// File: rtl/request_unit_q.sv
// In-order DEPTH-entry dmem request queue between the datapath and memory control,
// with halt draining, flush of unissued entries and a saturating head wait counter.
module request_unit_q #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              halt,
  input  logic              flush,
  output logic              imemren,
  output logic              dmemren,
  output logic              dmemwen,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              full,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  wait_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t            state;
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_n;
  logic [CW-1:0]     count, cnt_n;
  logic              q_ren [DEPTH];
  logic              q_wen [DEPTH];
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic              do_push, do_pop, do_flush;
  logic              h_ren, h_wen;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic [CNT_W-1:0]  wait_n;

  assign full    = (count == CW'(DEPTH));
  assign busy    = (count != '0);
  assign imemren = (state == RUN);
  assign halted  = (state == HALTED);

  always_comb begin
    do_flush = flush & (state != HALTED);
    do_pop   = dhit & busy;
    do_push  = ihit & (dREN | dWEN) & (state != HALTED)
             & (~full | dhit) & ~do_flush;
    rd_n     = rd_ptr + PW'(do_pop);
    if (do_flush)
      cnt_n = (busy & ~do_pop) ? CW'(1) : '0;
    else
      cnt_n = count + CW'(do_push) - CW'(do_pop);

    // The next head may be the entry being written this very edge.
    if (do_push && (wr_ptr == rd_n)) begin
      h_ren  = dREN & ~dWEN;
      h_wen  = dWEN;
      h_addr = daddr;
      h_data = dstore;
    end else begin
      h_ren  = q_ren[rd_n];
      h_wen  = q_wen[rd_n];
      h_addr = q_addr[rd_n];
      h_data = q_data[rd_n];
    end

    if (!busy || do_pop || cnt_n == '0)
      wait_n = '0;
    else if (wait_cnt == '1)
      wait_n = wait_cnt;
    else
      wait_n = wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_ren[i]  <= 1'b0;
        q_wen[i]  <= 1'b0;
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      state     <= RUN;
      wait_cnt  <= '0;
      dmemren   <= 1'b0;
      dmemwen   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
    end else begin
      if (do_push) begin
        q_ren[wr_ptr]  <= dREN & ~dWEN;
        q_wen[wr_ptr]  <= dWEN;
        q_addr[wr_ptr] <= daddr;
        q_data[wr_ptr] <= dstore;
      end
      rd_ptr   <= rd_n;
      wr_ptr   <= rd_n + cnt_n[PW-1:0];
      count    <= cnt_n;
      wait_cnt <= wait_n;

      if (cnt_n == '0) begin
        dmemren <= 1'b0;
        dmemwen <= 1'b0;
      end else begin
        dmemren   <= h_ren;
        dmemwen   <= h_wen;
        dmemaddr  <= h_addr;
        dmemstore <= h_data;
      end

      unique case (1'b1)
        state == RUN:   if (halt) state <= DRAIN;
        state == DRAIN: if (cnt_n == '0) state <= HALTED;
        default:        state <= HALTED;
      endcase
    end
  end

endmodule
